// File: rtl/rf_wb_arbiter_pkg.sv
// Shared register-file constants for the writeback arbiter and its scoreboard.
package pkg_rf;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned RA_W  = 5;
   localparam int unsigned NREGS = 32;
   localparam logic [RA_W-1:0] X0 = '0;
endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Per-register busy bits for in-flight long-unit destinations, with a
// three-source lookup that produces the decode stall.
module rf_scoreboard
   import pkg_rf::*;
#(
   parameter int unsigned RA_W  = pkg_rf::RA_W,
   parameter int unsigned NREGS = pkg_rf::NREGS
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            set_en,
   input  logic [RA_W-1:0] set_rd,
   input  logic            clr_en,
   input  logic [RA_W-1:0] clr_rd,
   input  logic [RA_W-1:0] rs1,
   input  logic [RA_W-1:0] rs2,
   input  logic [RA_W-1:0] rd,
   output logic            stall,
   output logic            any_busy
);
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_next;

   // Clear is applied before set so a same-cycle set on the same register wins.
   always_comb begin
      busy_next = busy;
      if (clr_en)
         busy_next[clr_rd] = 1'b0;
      if (set_en && set_rd != RA_W'(X0))
         busy_next[set_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         busy <= '0;
      else
         busy <= busy_next;
   end

   assign stall    = busy[rs1] | busy[rs2] | busy[rd];
   assign any_busy = |busy;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has fixed priority,
// long-unit results use valid/ready with a one-entry skid register.
module rf_wb_arbiter
   import pkg_rf::*;
#(
   parameter int unsigned XLEN  = pkg_rf::XLEN,
   parameter int unsigned RA_W  = pkg_rf::RA_W,
   parameter int unsigned NREGS = pkg_rf::NREGS
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wb_valid,
   input  logic [RA_W-1:0] wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            lu_issue,
   input  logic [RA_W-1:0] lu_issue_rd,
   input  logic            lu_valid,
   input  logic [RA_W-1:0] lu_rd,
   input  logic [XLEN-1:0] lu_data,
   output logic            lu_ready,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic [RA_W-1:0] id_rd,
   output logic            id_stall,
   output logic            lu_idle,
   output logic            rf_reg_write,
   output logic [RA_W-1:0] rf_rd,
   output logic [XLEN-1:0] rf_write_data
);
   logic            buf_valid, buf_valid_next;
   logic [RA_W-1:0] buf_rd, buf_rd_next;
   logic [XLEN-1:0] buf_data, buf_data_next;
   logic            accept;
   logic            clr_en;
   logic [RA_W-1:0] clr_rd;
   logic            any_busy;

   assign lu_ready = !buf_valid;
   assign accept   = lu_valid && lu_ready;

   // Only long-unit writes that reach the port retire their busy bit.
   always_comb begin
      rf_reg_write   = 1'b0;
      rf_rd          = '0;
      rf_write_data  = '0;
      clr_en         = 1'b0;
      clr_rd         = '0;
      buf_valid_next = buf_valid;
      buf_rd_next    = buf_rd;
      buf_data_next  = buf_data;
      if (wb_valid) begin
         rf_reg_write  = 1'b1;
         rf_rd         = wb_rd;
         rf_write_data = wb_data;
         if (accept) begin
            buf_valid_next = 1'b1;
            buf_rd_next    = lu_rd;
            buf_data_next  = lu_data;
         end
      end else if (buf_valid) begin
         rf_reg_write   = 1'b1;
         rf_rd          = buf_rd;
         rf_write_data  = buf_data;
         clr_en         = 1'b1;
         clr_rd         = buf_rd;
         buf_valid_next = 1'b0;
      end else if (accept) begin
         rf_reg_write  = 1'b1;
         rf_rd         = lu_rd;
         rf_write_data = lu_data;
         clr_en        = 1'b1;
         clr_rd        = lu_rd;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_valid <= 1'b0;
         buf_rd    <= '0;
         buf_data  <= '0;
      end else begin
         buf_valid <= buf_valid_next;
         buf_rd    <= buf_rd_next;
         buf_data  <= buf_data_next;
      end
   end

   rf_scoreboard #(
      .RA_W  (RA_W),
      .NREGS (NREGS)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .set_en   (lu_issue),
      .set_rd   (lu_issue_rd),
      .clr_en   (clr_en),
      .clr_rd   (clr_rd),
      .rs1      (id_rs1),
      .rs2      (id_rs2),
      .rd       (id_rd),
      .stall    (id_stall),
      .any_busy (any_busy)
   );

   assign lu_idle = !any_busy && !buf_valid;
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file.
- Shares that port between two requesters:
  - the in-order pipeline writeback, which is fixed priority and never back-pressured;
  - the long-latency execution unit (divider/multi-cycle load), which completes through a valid/ready handshake.
- Holds one losing long-unit result in a skid register.
- Keeps a per-register busy scoreboard for in-flight long-unit destinations and drives the decode-stage stall.

Parameters:
- XLEN, 32, data width of register values.
- RA_W, 5, register address width.
- NREGS, 32, number of architectural registers; must equal 2**RA_W.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- wb_valid  in  1  pipeline writeback request this cycle.
- wb_rd  in  RA_W  pipeline destination register.
- wb_data  in  XLEN  pipeline write data.
- lu_issue  in  1  long-unit operation leaves decode this cycle.
- lu_issue_rd  in  RA_W  destination of the issued long-unit op.
- lu_valid  in  1  long-unit result available.
- lu_rd  in  RA_W  long-unit result destination.
- lu_data  in  XLEN  long-unit result data.
- lu_ready  out  1  arbiter accepts the long-unit result this cycle.
- id_rs1  in  RA_W  decode source 1.
- id_rs2  in  RA_W  decode source 2.
- id_rd  in  RA_W  decode destination.
- id_stall  out  1  decode must hold.
- lu_idle  out  1  no long-unit op outstanding and skid buffer empty.
- rf_reg_write  out  1  register-file write enable.
- rf_rd  out  RA_W  register-file write address.
- rf_write_data  out  XLEN  register-file write data.

Behaviour:
- State:
  - buf_valid, buf_rd, buf_data (skid register);
  - busy[NREGS-1:0] scoreboard.
  - Reset sets all of these to 0. busy[0] is hard-wired to 0.
- Outputs:
  - The write port, lu_ready, id_stall and lu_idle are combinational from the current inputs and state.
  - The register file writes on the same edge, so writeback latency is 0 cycles added.
- With all inputs at 0 after reset: rf_reg_write=0, rf_rd=0, rf_write_data=0, lu_ready=1, id_stall=0, lu_idle=1.
- lu_ready = !buf_valid. It never depends on lu_valid or wb_valid. Accept = lu_valid && lu_ready.
- Write-port priority, evaluated per cycle:
  1. wb_valid=1: the port is driven from wb_rd/wb_data.
     - An accepted long-unit result is captured into the buffer (buf_valid<=1).
     - An existing buffer entry holds.
  2. wb_valid=0 and buf_valid=1: the port is driven from the buffer; buf_valid<=0.
     - lu_ready is 0 this cycle, so no accept can occur.
  3. wb_valid=0, buf_valid=0, accept: the long-unit result bypasses straight to the port.
  4. Otherwise rf_reg_write=0 and rf_rd/rf_write_data=0.
- Writes to rd 0 are passed through unchanged; the register file discards them.
- A long-unit result for rd 0 is accepted and written normally.
- Scoreboard:
  - lu_issue with lu_issue_rd!=0 sets busy[lu_issue_rd].
  - A long-unit write actually reaching the port (case 3, or case 2 drain) clears busy[rd].
  - Capture into the buffer does NOT clear busy.
  - Same register set and cleared in the same cycle: set wins.
- id_stall = busy[id_rs1] | busy[id_rs2] | busy[id_rd], where x0 never stalls.
  - busy clears on the same edge the register file is written.
  - Decode therefore reads the new value the cycle after id_stall drops; no bypass is needed.
- lu_idle = (busy==0) && !buf_valid.
- Interface contract (checked by the bench, not corrected in RTL):
  - No lu_issue to an rd that is already busy.
  - No wb_valid to a busy rd.
  - id_stall enforces both.
- Reset mid-operation: the buffer contents and busy bits are lost. The long unit must be flushed by the same reset.

Decomposition:
- Shared package pkg_rf: XLEN, RA_W, NREGS constants and the x0 address constant.
- One natural sub-module: rf_scoreboard, containing the busy vector with set/clear ports and the three-port lookup for stall.
- The arbitration and skid logic stay in rf_wb_arbiter.

Test Plan:
- Reset, then idle inputs -> rf_reg_write=0, lu_ready=1, id_stall=0, lu_idle=1.
- Bypass: wb_valid=0, lu_valid=1, lu_rd=7, lu_data=0xDEAD0007 -> same cycle rf_reg_write=1, rf_rd=7, rf_write_data=0xDEAD0007; busy[7] (set by an earlier lu_issue) clears next edge.
- Collision: lu_issue rd=9; later the same cycle carries wb_valid=1 rd=3 data=0x33 and lu_valid rd=9 data=0x99:
  - that cycle: port writes rd 3/0x33, lu_ready=1, buffer captures, id_stall stays 1 for id_rs1=9;
  - next cycle: lu_ready=0;
  - first cycle with wb_valid=0: port writes rd 9/0x99;
  - following cycle: id_stall=0.
- Sustained WB: buffer full with wb_valid=1 for 4 cycles -> lu_ready=0 all 4 cycles, buffer unchanged, drains in the first wb_valid=0 cycle.
- Scoreboard: lu_issue rd=5 -> id_stall=1 for each of id_rs1=5, id_rs2=5 and id_rd=5 alone. id_rs1=0 never stalls. Issue rd=0 sets nothing.
- Asynchronous reset asserted mid-cycle while buf_valid=1 and busy[12]=1 -> immediately buf_valid=0, busy=0, lu_ready=1, lu_idle=1.
